conv_layer_sched: RTL and testbench

- Generalised multi-filter convolution layer. Time-multiplexes K filters over P parallel convLayerSingle instances.
- Sequences filter groups with an explicit start/busy/done handshake.
- Captures each group's feature maps into a registered output bank. K need not be a multiple of P.
- Sits between the image/filter registers and the downstream pooling/activation stage.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_layer_sched_if.sv | 20 ++
 rtl/convLayerSingle.sv | 44 ++++
 rtl/conv_filter_bank_mux.sv | 25 ++
 rtl/conv_layer_sched.sv | 77 +++++++
 tb/tb_conv_layer_sched.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM states and geometry helpers for the convolution layer scheduler
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;
  function automatic int out_dim(input int n, input int f);
    return n - f + 1;
  endfunction
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
  function automatic int cnt_width(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/conv_layer_sched_if.sv
// conv_layer_sched_if: start/busy/done handshake plus image, filter and feature-map buses
interface conv_layer_sched_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int D = 1,
  parameter int H = 32,
  parameter int W = 32,
  parameter int F = 5,
  parameter int K = 6
);
  logic start;
  logic busy;
  logic done;
  logic [D*H*W*DATA_WIDTH-1:0] image;
  logic [K*D*F*F*DATA_WIDTH-1:0] filters;
  logic [K*out_dim(H, F)*out_dim(W, F)*DATA_WIDTH-1:0] outputConv;
  modport master(output start, image, filters, input busy, done, outputConv);
  modport slave(input start, image, filters, output busy, done, outputConv);
endinterface

// File: rtl/convLayerSingle.sv
// convLayerSingle: single-filter convolution, one output row per cycle after reset drops
module convLayerSingle
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int D = 1,
  parameter int H = 32,
  parameter int W = 32,
  parameter int F = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic [D*H*W*DATA_WIDTH-1:0] image,
  input  logic [D*F*F*DATA_WIDTH-1:0] filter,
  output logic [out_dim(H, F)*out_dim(W, F)*DATA_WIDTH-1:0] outputConv
);
  localparam int OH = out_dim(H, F);
  localparam int OW = out_dim(W, F);
  localparam int RW = $clog2(OH + 1);
  logic [RW-1:0] r;
  logic [OW-1:0][DATA_WIDTH-1:0] row;
  int base;
  assign base = r < RW'(OH) ? int'(r) : 0;
  // element 0 of every tensor sits at the MSB end, row-major, x=0 leftmost
  always_comb begin
    row = '0;
    for (int x = 0; x < OW; x++)
      for (int d = 0; d < D; d++)
        for (int a = 0; a < F; a++)
          for (int b = 0; b < F; b++)
            row[OW-1-x] = row[OW-1-x]
              + image[(D*H*W-1-((d*H+base+a)*W+x+b))*DATA_WIDTH +: DATA_WIDTH]
              * filter[(D*F*F-1-((d*F+a)*F+b))*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
      outputConv <= '0;
    end else if (r < RW'(OH)) begin
      outputConv[(OH-1-int'(r))*OW*DATA_WIDTH +: OW*DATA_WIDTH] <= row;
      r <= r + 1'b1;
    end
  end
endmodule

// File: rtl/conv_filter_bank_mux.sv
// conv_filter_bank_mux: picks the P filters of group g, zeroing slots past the last filter
module conv_filter_bank_mux
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int D = 1,
  parameter int F = 5,
  parameter int K = 6,
  parameter int P = 2
) (
  input  logic [K*D*F*F*DATA_WIDTH-1:0] filters,
  input  logic [cnt_width(ceil_div(K, P))-1:0] g,
  output logic [P-1:0][D*F*F*DATA_WIDTH-1:0] unit_filter,
  output logic [P-1:0] valid
);
  localparam int FS = D*F*F*DATA_WIDTH;
  for (genvar i = 0; i < P; i++) begin : g_slot
    int idx;
    int sel;
    assign idx = int'(g) * P + i;
    assign valid[i] = idx < K;
    assign sel = valid[i] ? K - 1 - idx : 0;
    assign unit_filter[i] = valid[i] ? filters[sel*FS +: FS] : '0;
  end
endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: time-multiplexes K filters over P convLayerSingle units, group by group
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int D = 1,
  parameter int H = 32,
  parameter int W = 32,
  parameter int F = 5,
  parameter int K = 6,
  parameter int P = 2,
  parameter int CONV_CYCLES = 1009
) (
  input logic clk,
  input logic reset,
  conv_layer_sched_if.slave bus
);
  localparam int OS = out_dim(H, F) * out_dim(W, F) * DATA_WIDTH;
  localparam int FS = D*F*F*DATA_WIDTH;
  localparam int G = ceil_div(K, P);
  localparam int CW = cnt_width(CONV_CYCLES);
  localparam int GW = cnt_width(G);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [GW-1:0] g;
  logic last_cnt, last_grp, unit_rst;
  logic [P-1:0] valid;
  logic [P-1:0][FS-1:0] unit_filter;
  logic [P-1:0][OS-1:0] unit_out;
  logic [K*OS-1:0] maps;
  int sel [P];
  assign last_cnt = cnt == CW'(CONV_CYCLES - 1);
  assign last_grp = g == GW'(G - 1);
  assign unit_rst = state != RUN;
  assign bus.busy = state inside {LOAD, RUN, CAPTURE};
  assign bus.done = state == DONE;
  assign bus.outputConv = maps;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? LOAD : IDLE;
      LOAD:    state_n = RUN;
      RUN:     state_n = last_cnt ? CAPTURE : RUN;
      CAPTURE: state_n = last_grp ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
  end
  // masked slots point at slice 0 but never write it
  always_comb begin
    for (int j = 0; j < P; j++) sel[j] = valid[j] ? K - 1 - (int'(g) * P + j) : 0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      g <= '0;
      maps <= '0;
    end else begin
      state <= state_n;
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      if (state == IDLE) g <= '0;
      else if (state == CAPTURE && !last_grp) g <= g + 1'b1;
      if (state == CAPTURE)
        for (int j = 0; j < P; j++)
          if (valid[j]) maps[sel[j]*OS +: OS] <= unit_out[j];
    end
  end
  conv_filter_bank_mux #(.DATA_WIDTH(DATA_WIDTH), .D(D), .F(F), .K(K), .P(P)) u_mux (
    .filters(bus.filters), .g(g), .unit_filter(unit_filter), .valid(valid)
  );
  for (genvar i = 0; i < P; i++) begin : g_unit
    convLayerSingle #(.DATA_WIDTH(DATA_WIDTH), .D(D), .H(H), .W(W), .F(F)) u_conv (
      .clk(clk), .reset(unit_rst), .image(bus.image), .filter(unit_filter[i]),
      .outputConv(unit_out[i])
    );
  end
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed checks of three scheduler configurations on a 6x6 image, 3x3 filters
module tb_conv_layer_sched;
  localparam int CC = 10;
  localparam int MB = 512;
  localparam int FB = 288;
  typedef struct packed {
    logic [31:0] img;
    logic [31:0] mult;
    int lat;
    int bz;
    logic [0:3][31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  conv_layer_sched_if #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(4)) b4 ();
  conv_layer_sched_if #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(5)) b5 ();
  conv_layer_sched_if #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(3)) b3 ();
  conv_layer_sched #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(4), .P(2), .CONV_CYCLES(CC))
    dut4 (.clk(clk), .reset(reset), .bus(b4));
  conv_layer_sched #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(5), .P(2), .CONV_CYCLES(CC))
    dut5 (.clk(clk), .reset(reset), .bus(b5));
  conv_layer_sched #(.DATA_WIDTH(32), .D(1), .H(6), .W(6), .F(3), .K(3), .P(3), .CONV_CYCLES(CC))
    dut3 (.clk(clk), .reset(reset), .bus(b3));

  task automatic chk(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [MB-1:0] fill(input logic [31:0] v);
    return {16{v}};
  endfunction

  function automatic int nk(input int w);
    return w == 0 ? 4 : w == 1 ? 5 : 3;
  endfunction

  function automatic logic [MB-1:0] map_of(input int w, input int k);
    if (w == 0) return b4.outputConv[(3-k)*MB +: MB];
    if (w == 1) return b5.outputConv[(4-k)*MB +: MB];
    return b3.outputConv[(2-k)*MB +: MB];
  endfunction

  function automatic logic busy_of(input int w);
    return w == 0 ? b4.busy : w == 1 ? b5.busy : b3.busy;
  endfunction

  function automatic logic done_of(input int w);
    return w == 0 ? b4.done : w == 1 ? b5.done : b3.done;
  endfunction

  function automatic logic [5*FB-1:0] filt(input int kk, input logic [31:0] mult);
    logic [5*FB-1:0] f;
    f = '0;
    for (int k = 0; k < kk; k++) f[(kk-1-k)*FB +: FB] = {9{32'(mult * 32'(k + 1))}};
    return f;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 0) b4.start = v;
    else if (w == 1) b5.start = v;
    else b3.start = v;
  endtask

  task automatic setup(input int w, input logic [31:0] img, input logic [31:0] mult);
    logic [5*FB-1:0] f;
    f = filt(nk(w), mult);
    if (w == 0) begin
      b4.image = {36{img}};
      b4.filters = f[4*FB-1:0];
    end else if (w == 1) begin
      b5.image = {36{img}};
      b5.filters = f;
    end else begin
      b3.image = {36{img}};
      b3.filters = f[3*FB-1:0];
    end
  endtask

  // pulses start now and watches until done plus a tail; bounded at 200 cycles
  task automatic run(input int w, input int restart_at, input int probe_at, input int tail,
                     output int lat, output int bcnt, output int dones,
                     output logic [4:0][MB-1:0] probe);
    int c;
    c = 0;
    lat = -1;
    bcnt = 0;
    dones = 0;
    probe = '0;
    set_start(w, 1'b1);
    while (c < 200 && (lat < 0 || c < lat + tail)) begin
      @(negedge clk);
      c++;
      set_start(w, c == restart_at);
      if (busy_of(w)) bcnt++;
      if (done_of(w)) begin
        dones++;
        if (lat < 0) lat = c;
      end
      if (c == probe_at)
        for (int k = 0; k < nk(w); k++) probe[k] = map_of(w, k);
    end
  endtask

  initial begin
    vec_t tbl [3];
    int lat, bcnt, dones;
    logic [4:0][MB-1:0] probe;
    logic [0:4][31:0] e5;
    tbl[0] = '{img: 32'd1, mult: 32'd1, lat: 25, bz: 24, exp: {32'd9, 32'd18, 32'd27, 32'd36}};
    tbl[1] = '{img: 32'd2, mult: 32'd1, lat: 25, bz: 24, exp: {32'd18, 32'd36, 32'd54, 32'd72}};
    tbl[2] = '{img: 32'd3, mult: 32'd2, lat: 25, bz: 24, exp: {32'd54, 32'd108, 32'd162, 32'd216}};
    for (int w = 0; w < 3; w++) begin
      set_start(w, 1'b0);
      setup(w, 32'd1, 32'd1);
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk_int($sformatf("reset busy w%0d", w), int'(busy_of(w)), 0);
      chk_int($sformatf("reset done w%0d", w), int'(done_of(w)), 0);
      for (int k = 0; k < nk(w); k++) chk($sformatf("reset w%0d map%0d", w, k), map_of(w, k), '0);
    end
    reset = 1'b1;
    @(negedge clk);
    // K=4, P=2 table runs, each started the cycle after the previous done
    for (int v = 0; v < 3; v++) begin
      setup(0, tbl[v].img, tbl[v].mult);
      run(0, -1, -1, 1, lat, bcnt, dones, probe);
      chk_int($sformatf("v%0d latency", v), lat, tbl[v].lat);
      chk_int($sformatf("v%0d busy cycles", v), bcnt, tbl[v].bz);
      chk_int($sformatf("v%0d done pulses", v), dones, 1);
      for (int k = 0; k < 4; k++) chk($sformatf("v%0d map%0d", v, k), map_of(0, k), fill(tbl[v].exp[k]));
    end
    setup(0, 32'd1, 32'd1);
    run(0, -1, 13, 1, lat, bcnt, dones, probe);
    chk("b2b mid map0", probe[0], fill(32'd9));
    chk("b2b mid map1", probe[1], fill(32'd18));
    chk("b2b mid map2", probe[2], fill(32'd162));
    chk("b2b mid map3", probe[3], fill(32'd216));
    chk_int("b2b latency", lat, 25);
    for (int k = 0; k < 4; k++) chk($sformatf("b2b map%0d", k), map_of(0, k), fill(32'(9 * (k + 1))));
    setup(0, 32'd2, 32'd1);
    run(0, 6, -1, 30, lat, bcnt, dones, probe);
    chk_int("restart latency", lat, 25);
    chk_int("restart done pulses", dones, 1);
    chk_int("restart busy cycles", bcnt, 24);
    chk("restart map3", map_of(0, 3), fill(32'd72));
    setup(0, 32'd3, 32'd1);
    set_start(0, 1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      set_start(0, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk_int("abort busy", int'(b4.busy), 0);
    chk_int("abort done", int'(b4.done), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("abort map%0d", k), map_of(0, k), '0);
    reset = 1'b1;
    run(0, -1, -1, 1, lat, bcnt, dones, probe);
    chk_int("post-abort latency", lat, 25);
    for (int k = 0; k < 4; k++) chk($sformatf("post-abort map%0d", k), map_of(0, k), fill(32'(27 * (k + 1))));
    // K=5, P=2: partial last group, second run over a pre-filled bank
    setup(1, 32'd2, 32'd1);
    run(1, -1, -1, 1, lat, bcnt, dones, probe);
    chk_int("k5 latency", lat, 37);
    chk_int("k5 busy cycles", bcnt, 36);
    e5 = {32'd18, 32'd36, 32'd54, 32'd72, 32'd90};
    for (int k = 0; k < 5; k++) chk($sformatf("k5 run1 map%0d", k), map_of(1, k), fill(e5[k]));
    setup(1, 32'd1, 32'd1);
    run(1, -1, 13, 1, lat, bcnt, dones, probe);
    chk("k5 mid map1", probe[1], fill(32'd18));
    chk("k5 mid map2", probe[2], fill(32'd54));
    chk("k5 mid map4", probe[4], fill(32'd90));
    chk_int("k5 run2 latency", lat, 37);
    e5 = {32'd9, 32'd18, 32'd27, 32'd36, 32'd45};
    for (int k = 0; k < 5; k++) chk($sformatf("k5 run2 map%0d", k), map_of(1, k), fill(e5[k]));
    // K=P=3: single group
    setup(2, 32'd1, 32'd1);
    run(2, -1, -1, 1, lat, bcnt, dones, probe);
    chk_int("k3 latency", lat, CC + 3);
    chk_int("k3 busy cycles", bcnt, CC + 2);
    chk_int("k3 done pulses", dones, 1);
    for (int k = 0; k < 3; k++) chk($sformatf("k3 map%0d", k), map_of(2, k), fill(32'(9 * (k + 1))));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
